// File: rtl/core2_job_loader.sv
// core2_job_loader: gathers a header word plus two multi-word operands from a
// 32-bit valid/ready stream, then pushes operand A/B and the 4-bit command into
// the Core2 input and command FIFOs in the same cycle.
//
// Stream handshake: a word transfers on a rising edge where s_valid && s_ready.
// s_ready depends only on state (low in PUSH only), never on s_valid. A word
// offered while flush is high transfers but is discarded.
//
// Optional feature: define CORE2_JOB_COUNTER_EN to add the 16-bit jobs_done
// counter output. With the macro undefined, that port and its logic are absent.
// dbg_state exposes the FSM encoding (0 IDLE, 1 LOAD_A, 2 LOAD_B, 3 PUSH).
module core2_job_loader #(
  parameter int         WORD_W  = 32,
  parameter int         OPER_W  = 128,
  parameter logic [3:0] HDR_TAG = 4'hA
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  input  logic              in_busy_inp,
  input  logic              in_busy_cmd,
  output logic              wr_en_inp,
  output logic [OPER_W-1:0] data_a,
  output logic [OPER_W-1:0] data_b,
  output logic              wr_en_cmd,
  output logic [3:0]        cmd,
  output logic              hdr_err,
`ifdef CORE2_JOB_COUNTER_EN
  output logic [15:0]       jobs_done,
`endif
  output logic [1:0]        dbg_state
);

  localparam int NWORDS = OPER_W / WORD_W;
  localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD_A = 2'd1,
    S_LOAD_B = 2'd2,
    S_PUSH   = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              w_push;
  logic              w_xfer;
  logic              w_tag_ok;
  logic              w_last;
  logic [IDX_W-1:0]  r_idx;
  logic [OPER_W-1:0] r_data_a;
  logic [OPER_W-1:0] r_data_b;
  logic [3:0]        r_cmd;
  logic              r_wr_en;
  logic              r_hdr_err;

  assign s_ready   = (r_state != S_PUSH);
  assign w_xfer    = s_valid && s_ready;
  assign w_tag_ok  = (s_data[WORD_W-1 -: 4] == HDR_TAG);
  assign w_last    = (r_idx == LAST_IDX);

  assign wr_en_inp = r_wr_en;
  assign wr_en_cmd = r_wr_en;
  assign data_a    = r_data_a;
  assign data_b    = r_data_b;
  assign cmd       = r_cmd;
  assign hdr_err   = r_hdr_err;
  assign dbg_state = r_state;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state and push decision; flush overrides everything else.
  always_comb begin
    w_next_state = r_state;
    w_push       = 1'b0;
    if (flush) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (w_xfer && w_tag_ok) w_next_state = S_LOAD_A;
        S_LOAD_A: if (w_xfer && w_last)   w_next_state = S_LOAD_B;
        S_LOAD_B: if (w_xfer && w_last)   w_next_state = S_PUSH;
        S_PUSH: begin
          if (!in_busy_inp && !in_busy_cmd) begin
            w_push       = 1'b1;
            w_next_state = S_IDLE;
          end
        end
        default:  w_next_state = S_IDLE;
      endcase
    end
  end

  // Datapath: header decode, operand slice writes, push pulse, sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx     <= '0;
      r_data_a  <= '0;
      r_data_b  <= '0;
      r_cmd     <= 4'h0;
      r_wr_en   <= 1'b0;
      r_hdr_err <= 1'b0;
    end else begin
      r_wr_en <= w_push;
      if (flush) begin
        r_idx <= '0;
      end else if (w_xfer) begin
        case (r_state)
          S_IDLE: begin
            if (w_tag_ok) begin
              r_cmd <= s_data[3:0];
              r_idx <= '0;
            end else begin
              r_hdr_err <= 1'b1;
            end
          end
          S_LOAD_A: begin
            r_data_a[int'(r_idx)*WORD_W +: WORD_W] <= s_data;
            r_idx <= w_last ? '0 : r_idx + 1'b1;
          end
          S_LOAD_B: begin
            r_data_b[int'(r_idx)*WORD_W +: WORD_W] <= s_data;
            r_idx <= w_last ? '0 : r_idx + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef CORE2_JOB_COUNTER_EN
  logic [15:0] r_jobs_done;
  assign jobs_done = r_jobs_done;

  // Completed-job counter; advances on the edge that raises the push pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_jobs_done <= 16'h0;
    else if (w_push) r_jobs_done <= r_jobs_done + 16'h1;
  end
`endif

endmodule
